// File: rtl/macrocell_config_loader_pkg.sv
// rtl/macrocell_config_loader_pkg.sv - shared bitstream package: load FSM encoding and size/index-width helpers
package macrocell_config_loader_pkg;

    // Load sequencer states; also used by the macrocell decoders.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

    localparam int default_num_labs           = 2;
    localparam int default_macrocells_per_lab = 16;
    localparam int default_bits_per_macrocell = 13;

    // Total configuration bits for a device.
    function automatic int block_size(input int labs, input int mcs, input int bits);
        return labs * mcs * bits;
    endfunction

    // Width of a counter that must reach n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of a selector for n items, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/macrocell_config_loader_if.sv
// rtl/macrocell_config_loader_if.sv - serial configuration bit stream handshake
// Signals: bit_in (serial bit), bit_valid (bit_in valid), bit_ready (loader accepts this cycle).
// master = bit source, slave = loader.
interface macrocell_config_loader_if;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;

    modport master (output bit_in, output bit_valid, input bit_ready);
    modport slave  (input bit_in, input bit_valid, output bit_ready);
endinterface

// File: rtl/macrocell_field_select.sv
// rtl/macrocell_field_select.sv - registered per-macrocell field readout with selector range check
// Ports: clk, reset (async high), block (assembled configuration), sel_lab, sel_macrocell,
//        macrocell_bits (selected field, one-cycle latency), sel_error (selector out of range).
module macrocell_field_select
    import macrocell_config_loader_pkg::*;
#(
    parameter int num_labs           = default_num_labs,
    parameter int macrocells_per_lab = default_macrocells_per_lab,
    parameter int bits_per_macrocell = default_bits_per_macrocell
) (
    input  logic                                                                  clk,
    input  logic                                                                  reset,
    input  logic [block_size(num_labs, macrocells_per_lab, bits_per_macrocell)-1:0] block,
    input  logic [sel_width(num_labs)-1:0]                                        sel_lab,
    input  logic [sel_width(macrocells_per_lab)-1:0]                              sel_macrocell,
    output logic [bits_per_macrocell-1:0]                                         macrocell_bits,
    output logic                                                                  sel_error
);

    localparam int size_cb = block_size(num_labs, macrocells_per_lab, bits_per_macrocell);

    logic               in_range;
    logic [31:0]        base;
    logic [size_cb-1:0] shifted;

    // A shift rather than a variable part-select keeps out-of-range bases harmless;
    // the range check then zeroes whatever falls out.
    always_comb begin
        in_range = (int'(sel_lab) < num_labs) && (int'(sel_macrocell) < macrocells_per_lab);
        base     = (int'(sel_lab) * macrocells_per_lab + int'(sel_macrocell)) * bits_per_macrocell;
        shifted  = block >> base;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            macrocell_bits <= '0;
            sel_error      <= 1'b0;
        end else begin
            macrocell_bits <= in_range ? shifted[bits_per_macrocell-1:0] : '0;
            sel_error      <= !in_range;
        end
    end

endmodule

// File: rtl/macrocell_config_loader.sv
// rtl/macrocell_config_loader.sv - serial loader assembling the macrocell configuration block
// Ports: clk, reset (async high), start, abort, bit_stream (slave: bit_in/bit_valid/bit_ready),
//        busy, done, bit_count, macrocell_configuration_block, sel_lab, sel_macrocell,
//        macrocell_bits, sel_error.
module macrocell_config_loader
    import macrocell_config_loader_pkg::*;
#(
    parameter int num_labs           = default_num_labs,
    parameter int macrocells_per_lab = default_macrocells_per_lab,
    parameter int bits_per_macrocell = default_bits_per_macrocell
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                abort,
    macrocell_config_loader_if.slave            bit_stream,
    output logic                                busy,
    output logic                                done,
    output logic [count_width(block_size(num_labs, macrocells_per_lab, bits_per_macrocell))-1:0] bit_count,
    output logic [block_size(num_labs, macrocells_per_lab, bits_per_macrocell)-1:0]             macrocell_configuration_block,
    input  logic [sel_width(num_labs)-1:0]           sel_lab,
    input  logic [sel_width(macrocells_per_lab)-1:0] sel_macrocell,
    output logic [bits_per_macrocell-1:0]            macrocell_bits,
    output logic                                     sel_error
);

    localparam int size_configuration_block = block_size(num_labs, macrocells_per_lab, bits_per_macrocell);
    localparam int count_w                  = count_width(size_configuration_block);
    localparam logic [count_w-1:0] last_index = count_w'(size_configuration_block - 1);

    load_state_t state_q;
    load_state_t state_d;
    logic        clear_block;
    logic        accept_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        clear_block          = 1'b0;
        accept_bit           = 1'b0;
        busy                 = 1'b0;
        done                 = 1'b0;
        bit_stream.bit_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    clear_block = 1'b1;
                end
            end
            ST_LOAD: begin
                busy                 = 1'b1;
                bit_stream.bit_ready = 1'b1;
                // abort wins over a bit offered on the same edge
                if (abort) begin
                    state_d     = ST_IDLE;
                    clear_block = 1'b1;
                end else if (bit_stream.bit_valid) begin
                    accept_bit = 1'b1;
                    if (bit_count == last_index) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d     = ST_LOAD;
                    clear_block = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_count                     <= '0;
            macrocell_configuration_block <= '0;
        end else if (clear_block) begin
            bit_count                     <= '0;
            macrocell_configuration_block <= '0;
        end else if (accept_bit) begin
            macrocell_configuration_block[bit_count] <= bit_stream.bit_in;
            bit_count                                <= bit_count + count_w'(1);
        end
    end

    macrocell_field_select #(
        .num_labs           (num_labs),
        .macrocells_per_lab (macrocells_per_lab),
        .bits_per_macrocell (bits_per_macrocell)
    ) u_field_select (
        .clk            (clk),
        .reset          (reset),
        .block          (macrocell_configuration_block),
        .sel_lab        (sel_lab),
        .sel_macrocell  (sel_macrocell),
        .macrocell_bits (macrocell_bits),
        .sel_error      (sel_error)
    );

endmodule

// File: doc/macrocell_config_loader.md
MACROCELL_CONFIG_LOADER -- requirements
Module: macrocell_config_loader

Interface
REQ-001 SHALL have parameter num_labs, default 2, number of LABs (index 0 = LAB "A").
REQ-002 SHALL have parameter macrocells_per_lab, default 16, macrocells per LAB.
REQ-003 SHALL have parameter bits_per_macrocell, default 13, configuration bits per macrocell.
REQ-004 SHALL derive size_configuration_block = num_labs * macrocells_per_lab * bits_per_macrocell (default 416).
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, begin a new load.
REQ-008 SHALL have port abort, input, 1, cancel an in-progress load.
REQ-009 SHALL have port bit_in, input, 1, serial configuration bit.
REQ-010 SHALL have port bit_valid, input, 1, bit_in is valid.
REQ-011 SHALL have port bit_ready, output, 1, loader accepts a bit this cycle.
REQ-012 SHALL have port busy, output, 1, high in LOAD.
REQ-013 SHALL have port done, output, 1, block complete and valid.
REQ-014 SHALL have port bit_count, output, clog2(size_configuration_block+1), bits accepted so far.
REQ-015 SHALL have port macrocell_configuration_block, output, size_configuration_block, assembled block.
REQ-016 SHALL have port sel_lab, input, clog2(num_labs) (min 1), LAB selector for field readout.
REQ-017 SHALL have port sel_macrocell, input, clog2(macrocells_per_lab) (min 1), macrocell selector.
REQ-018 SHALL have port macrocell_bits, output, bits_per_macrocell, selected macrocell's field.
REQ-019 SHALL have port sel_error, output, 1, selector out of range.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-021 IDLE: start -> LOAD; block and bit_count cleared to 0 on that edge.
REQ-022 LOAD: bit_ready=1; a bit is accepted on any edge with bit_valid=1.
REQ-023 Accepted bit SHALL be written to block[bit_count], then bit_count increments (stream bit 0 -> block bit 0).
REQ-024 Acceptance of the bit with bit_count = size-1 SHALL move to DONE on the same edge; bit_count then equals size.
REQ-025 bit_ready SHALL be 0 outside LOAD; bit_valid outside LOAD SHALL be ignored with no state change.
REQ-026 abort in LOAD SHALL go to IDLE, clear bit_count and block; abort SHALL take priority over a simultaneous valid bit.
REQ-027 abort in IDLE or DONE SHALL be ignored.
REQ-028 start in LOAD SHALL be ignored; start in DONE SHALL clear block/bit_count and enter LOAD.
REQ-029 done SHALL be 1 exactly while in DONE; busy exactly while in LOAD.
REQ-030 macrocell_bits SHALL be registered, one-cycle latency: block[((sel_lab*macrocells_per_lab)+sel_macrocell)*bits_per_macrocell +: bits_per_macrocell].
REQ-031 Readout SHALL operate in all states (partial contents visible during LOAD).
REQ-032 Out-of-range sel_lab or sel_macrocell SHALL yield macrocell_bits = 0 and sel_error = 1, same one-cycle latency.

Reset
REQ-033 reset SHALL asynchronously force IDLE, bit_count=0, block=0, macrocell_bits=0, sel_error=0.
REQ-034 Resulting outputs: bit_ready=0, busy=0, done=0; reset mid-LOAD discards partial data.
REQ-035 First edge after reset deassertion SHALL behave as normal IDLE.

Structure
REQ-036 FSM state encoding and size/index-width constants SHALL live in a shared bitstream package reused by the macrocell decoders.
REQ-037 Field readout SHALL be a sub-module macrocell_field_select (registered mux plus range check).

Verification
REQ-038 Reset, start, stream 416 bits with bit_valid always 1 -> done high after the 416th accepted bit, bit_count=416, block equals stream.
REQ-039 Stream with bit_valid toggling every other cycle -> only valid bits stored, done after 416 accepted, no gaps.
REQ-040 abort with a valid bit at bit_count=100 -> IDLE, bit_count=0, block=0, bit not stored.
REQ-041 After full load with block bits 13..25 = 13'h1ABC, sel_lab=0, sel_macrocell=1 -> macrocell_bits=13'h1ABC next cycle, sel_error=0.
REQ-042 Parameter num_labs=3, sel_lab=3 -> macrocell_bits=0, sel_error=1.
REQ-043 reset asserted mid-cycle at bit_count=200 -> outputs clear immediately without clock edge; start in DONE restarts from bit_count=0.
